// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer that drives a shared 1-bit ALU LSB-first for WIDTH cycles.
// Optional zero flag output enabled by defining ALU_SERIAL_ZERO_FLAG_EN.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_sel,
    input  logic             alu_y,
    input  logic             alu_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [2:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             arith_op;
    logic             last_bit;
    logic [WIDTH-1:0] result_nx;

    // Only ADD and SUB chain a carry/borrow between bit slices.
    assign arith_op  = (op_q[2:1] == 2'b00);
    assign last_bit  = (cnt == CNT_LAST);
    assign result_nx = {alu_y, result[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        alu_a    = 1'b0;
        alu_b    = 1'b0;
        alu_cin  = 1'b0;
        alu_sel  = 3'b000;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                alu_a   = a_sh[0];
                alu_b   = b_sh[0];
                alu_cin = arith_op ? carry : 1'b0;
                alu_sel = op_q;
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands are captured once on acceptance; later input changes are invisible.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            op_q      <= 3'b000;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zero      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh      <= a_in;
                        b_sh      <= b_in;
                        op_q      <= op;
                        carry     <= 1'b0;
                        cnt       <= '0;
                        result    <= '0;
                        carry_out <= 1'b0;
                    end
                end
                RUN: begin
                    result <= result_nx;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= alu_cout;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        carry_out <= arith_op ? alu_cout : 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                        zero      <= (result_nx == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
